safe_wrapper_sync_ctrl: RTL and testbench

- Sequencer that brings the cores of the safe wrapper into a synchronised start.
- On a rising edge of the start request it selects the cores involved by safe mode and configuration, then halts them through debug requests.
- It waits for every selected core to report halted, then releases them together and tracks the run until the software routine ends.
- Sits between the safe wrapper control register block and the per-core debug request lines.

---
 rtl/safe_wrapper_sync_ctrl.sv | 172 +++++++++++++++++
 tb/tb_safe_wrapper_sync_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/safe_wrapper_sync_ctrl.sv
// Synchronised-start sequencer for the safe wrapper cores.
// Halts the selected cores, releases them together and tracks the run.
module safe_wrapper_sync_ctrl #(
    parameter int unsigned          NCORES    = 3,
    parameter int unsigned          TIMEOUT_W = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 16'd1000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              safe_mode_i,
    input  logic [1:0]        safe_configuration_i,
    input  logic [NCORES-1:0] master_core_i,
    input  logic              critical_section_i,
    input  logic              end_sw_routine_i,
    input  logic [NCORES-1:0] core_halted_i,
    output logic [NCORES-1:0] debug_req_o,
    output logic [NCORES-1:0] active_cores_o,
    output logic              sync_done_o,
    output logic              busy_o,
    output logic              end_ack_o,
    output logic              timeout_err_o,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HALT_REQ  = 3'd1,
        S_WAIT_HALT = 3'd2,
        S_RESUME    = 3'd3,
        S_RUN       = 3'd4,
        S_ERROR     = 3'd5
    } state_e;

    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT - 1'b1;

    state_e                 r_state;
    logic [NCORES-1:0]      r_active;
    logic [TIMEOUT_W-1:0]   r_cnt;
    logic                   r_start_q;
    logic                   r_end_q;
    logic                   r_armed;
    logic                   r_pend;
    logic                   r_terr;

    logic [NCORES-1:0]      w_master;
    logic [NCORES-1:0]      w_rot;
    logic [NCORES-1:0]      w_sel;
    logic                   w_start_rise;
    logic                   w_end_rise;
    logic                   w_end_req;
    logic                   w_all_halted;
    logic                   w_done;

    assign w_master = $onehot(master_core_i) ? master_core_i
                                             : NCORES'(1);
    assign w_rot    = {w_master[NCORES-2:0], w_master[NCORES-1]};

    always_comb begin
        w_sel = w_master;
        case (safe_configuration_i)
            2'b00:   w_sel = '1;
            2'b01:   w_sel = w_master | w_rot;
            default: w_sel = w_master;
        endcase
    end

    // r_armed keeps a start level held since reset from counting as an edge
    assign w_start_rise = start_i & ~r_start_q & r_armed;
    assign w_end_rise   = end_sw_routine_i & ~r_end_q;
    assign w_end_req    = r_pend | w_end_rise;
    assign w_all_halted = ((core_halted_i & r_active) == r_active);
    assign w_done       = (r_state == S_RUN) & start_i
                        & w_end_req & ~critical_section_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_active  <= '0;
            r_cnt     <= '0;
            r_start_q <= 1'b0;
            r_end_q   <= 1'b0;
            r_armed   <= 1'b0;
            r_pend    <= 1'b0;
            r_terr    <= 1'b0;
        end else begin
            r_start_q <= start_i;
            r_end_q   <= end_sw_routine_i;
            if (!start_i) begin
                r_armed <= 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_start_rise) begin
                        r_active <= w_sel;
                        r_terr   <= 1'b0;
                        r_pend   <= 1'b0;
                        r_state  <= safe_mode_i ? S_HALT_REQ : S_RUN;
                    end
                end
                S_HALT_REQ: begin
                    if (!start_i) begin
                        r_state  <= S_IDLE;
                        r_active <= '0;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT_HALT;
                    end
                end
                S_WAIT_HALT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!start_i) begin
                        r_state  <= S_IDLE;
                        r_active <= '0;
                    end else if (w_all_halted) begin
                        r_state <= S_RESUME;
                    end else if (r_cnt == TO_LAST) begin
                        r_state <= S_ERROR;
                        r_terr  <= 1'b1;
                    end
                end
                S_RESUME: begin
                    if (!start_i) begin
                        r_state  <= S_IDLE;
                        r_active <= '0;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!start_i || w_done) begin
                        r_state  <= S_IDLE;
                        r_active <= '0;
                        r_pend   <= 1'b0;
                    end else if (w_end_rise) begin
                        r_pend <= 1'b1;
                    end
                end
                S_ERROR: begin
                    if (!start_i) begin
                        r_state  <= S_IDLE;
                        r_active <= '0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_active <= '0;
                end
            endcase
        end
    end

    // Requests are dropped in the same cycle start_i falls
    always_comb begin
        debug_req_o = '0;
        if (start_i) begin
            if (r_state == S_HALT_REQ) begin
                debug_req_o = r_active;
            end else if (r_state == S_WAIT_HALT) begin
                debug_req_o = r_active & ~core_halted_i;
            end
        end
    end

    assign active_cores_o = r_active;
    assign sync_done_o    = (r_state == S_RESUME) & start_i;
    assign busy_o         = (r_state != S_IDLE);
    assign end_ack_o      = w_done;
    assign timeout_err_o  = r_terr;
    assign state_o        = r_state;

endmodule

// File: tb/tb_safe_wrapper_sync_ctrl.sv
// Bench for safe_wrapper_sync_ctrl: directed scenarios plus randomized
// halt orders checked against a scenario-level expectation model.
module tb_safe_wrapper_sync_ctrl;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       start;
    logic       safe;
    logic [1:0] cfg;
    logic [2:0] master;
    logic       crit;
    logic       endsw;
    logic [2:0] halted;
    logic [2:0] dbg;
    logic [2:0] act;
    logic       sync;
    logic       busy;
    logic       ack;
    logic       terr;
    logic [2:0] st;

    int n_checks = 0;
    int n_err    = 0;

    safe_wrapper_sync_ctrl #(
        .NCORES    (3),
        .TIMEOUT_W (16),
        .TIMEOUT   (16'd8)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_ni),
        .start_i              (start),
        .safe_mode_i          (safe),
        .safe_configuration_i (cfg),
        .master_core_i        (master),
        .critical_section_i   (crit),
        .end_sw_routine_i     (endsw),
        .core_halted_i        (halted),
        .debug_req_o          (dbg),
        .active_cores_o       (act),
        .sync_done_o          (sync),
        .busy_o               (busy),
        .end_ack_o            (ack),
        .timeout_err_o        (terr),
        .state_o              (st)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] exp_active(input logic [1:0] c,
                                              input logic [2:0] m);
        logic [2:0] s;
        s = (m == 3'd1 || m == 3'd2 || m == 3'd4) ? m : 3'd1;
        if (c == 2'd0) return 3'd7;
        if (c == 2'd1) return s | (s << 1) | (s >> 2);
        return s;
    endfunction

    // Drives a safe start and walks it to RUN (ok=1) or to IDLE after a timeout
    task automatic do_safe_run(input logic [1:0] c, input logic [2:0] m,
                               input int d0, input int d1, input int d2,
                               output bit ok);
        logic [2:0] ea;
        logic [2:0] h;
        bit         all;
        int         t;
        ea = exp_active(c, m);
        safe = 1'b1; cfg = c; master = m; halted = 3'd0; start = 1'b1;
        #1;
        n_checks++;
        if (st !== 3'd0) begin
            n_err++; $display("FAIL idle_before_edge got %0d exp 0", st);
        end
        @(negedge clk);
        cfg = ~c; master = ~m; safe = 1'b0;
        #1;
        n_checks++;
        if (st !== 3'd1 || dbg !== ea || act !== ea || terr !== 1'b0) begin
            n_err++;
            $display("FAIL halt_req got st=%0d dbg=%b act=%b terr=%b exp st=1 dbg=%b act=%b terr=0",
                     st, dbg, act, terr, ea, ea);
        end
        @(negedge clk);
        ok = 1'b0;
        for (t = 0; t < 64; t++) begin
            h = {t >= d2, t >= d1, t >= d0};
            halted = h;
            #1;
            n_checks++;
            if (st !== 3'd2 || dbg !== (ea & ~h)) begin
                n_err++;
                $display("FAIL wait_halt t=%0d got st=%0d dbg=%b exp st=2 dbg=%b",
                         t, st, dbg, ea & ~h);
            end
            all = ((h & ea) == ea);
            @(negedge clk);
            if (all) begin
                ok = 1'b1;
                break;
            end
            if (t == TO - 1) break;
        end
        #1;
        if (ok) begin
            n_checks++;
            if (st !== 3'd3 || sync !== 1'b1 || dbg !== 3'd0) begin
                n_err++;
                $display("FAIL resume got st=%0d sync=%b dbg=%b exp st=3 sync=1 dbg=0",
                         st, sync, dbg);
            end
            @(negedge clk);
            #1;
            n_checks++;
            if (st !== 3'd4 || sync !== 1'b0 || act !== ea || busy !== 1'b1) begin
                n_err++;
                $display("FAIL run_entry got st=%0d sync=%b act=%b exp st=4 sync=0 act=%b",
                         st, sync, act, ea);
            end
        end else begin
            n_checks++;
            if (st !== 3'd5 || terr !== 1'b1 || dbg !== 3'd0 || t != TO - 1) begin
                n_err++;
                $display("FAIL timeout got st=%0d terr=%b dbg=%b waits=%0d exp st=5 terr=1 dbg=0 waits=%0d",
                         st, terr, dbg, t + 1, TO);
            end
            start = 1'b0;
            @(negedge clk);
            #1;
            n_checks++;
            if (st !== 3'd0 || terr !== 1'b1 || act !== 3'd0) begin
                n_err++;
                $display("FAIL err_exit got st=%0d terr=%b act=%b exp st=0 terr=1 act=0",
                         st, terr, act);
            end
        end
    endtask

    task automatic finish_run(input int hold);
        if (hold == 0) begin
            crit = 1'b0; endsw = 1'b1;
            #1;
        end else begin
            crit = 1'b1; endsw = 1'b1;
            #1;
            n_checks++;
            if (ack !== 1'b0) begin
                n_err++; $display("FAIL crit_edge_ack got %b exp 0", ack);
            end
            @(negedge clk);
            endsw = 1'b0;
            repeat (hold) begin
                #1;
                n_checks++;
                if (ack !== 1'b0 || st !== 3'd4) begin
                    n_err++;
                    $display("FAIL crit_hold got ack=%b st=%0d exp ack=0 st=4", ack, st);
                end
                @(negedge clk);
            end
            crit = 1'b0;
            #1;
        end
        n_checks++;
        if (ack !== 1'b1) begin
            n_err++; $display("FAIL end_ack got %b exp 1", ack);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (st !== 3'd0 || busy !== 1'b0 || act !== 3'd0 || ack !== 1'b0) begin
            n_err++;
            $display("FAIL run_exit got st=%0d busy=%b act=%b ack=%b exp 0 0 000 0",
                     st, busy, act, ack);
        end
        endsw = 1'b0; crit = 1'b0; start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_ni = 1'b0; start = 1'b1; safe = 1'b1; cfg = 2'd0; master = 3'd1;
        crit = 1'b0; endsw = 1'b0; halted = 3'd0;
        #3;
        n_checks++;
        if ({dbg, act, sync, busy, ack, terr, st} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_outputs got %b exp 0", {dbg, act, sync, busy, ack, terr, st});
        end
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (st !== 3'd0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL held_start got st=%0d busy=%b exp 0 0", st, busy);
            end
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_tmr;
        bit ok;
        do_safe_run(2'd0, 3'b010, 0, 1, 2, ok);
        if (ok) finish_run(0);
    endtask

    task automatic test_dmr;
        bit ok;
        do_safe_run(2'd1, 3'b100, 0, 99, 0, ok);
        if (ok) finish_run(0);
        do_safe_run(2'd1, 3'b011, 0, 0, 99, ok);
        if (ok) finish_run(1);
    endtask

    task automatic test_timeout;
        bit ok;
        do_safe_run(2'd0, 3'b001, 0, 0, 99, ok);
        n_checks++;
        if (ok !== 1'b0) begin
            n_err++; $display("FAIL timeout_taken got ok=%b exp 0", ok);
        end
        do_safe_run(2'd0, 3'b001, TO - 1, TO - 1, TO - 1, ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_err++; $display("FAIL halt_wins_tie got ok=%b exp 1", ok);
        end
        if (ok) finish_run(0);
    endtask

    task automatic test_critical;
        bit ok;
        do_safe_run(2'd2, 3'b100, 2, 2, 0, ok);
        if (ok) finish_run(4);
    endtask

    task automatic test_nonsafe;
        safe = 1'b0; cfg = 2'd2; master = 3'b001; start = 1'b1;
        #1;
        n_checks++;
        if (dbg !== 3'd0) begin
            n_err++; $display("FAIL ns_edge_dbg got %b exp 000", dbg);
        end
        @(negedge clk);
        repeat (3) begin
            halted = 3'($urandom_range(0, 7));
            #1;
            n_checks++;
            if (st !== 3'd4 || dbg !== 3'd0 || sync !== 1'b0 ||
                act !== 3'b001 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL ns_run got st=%0d dbg=%b sync=%b act=%b busy=%b exp 4 000 0 001 1",
                         st, dbg, sync, act, busy);
            end
            @(negedge clk);
        end
        finish_run(0);
    endtask

    task automatic test_abort;
        safe = 1'b1; cfg = 2'd0; master = 3'b001; halted = 3'd0; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        halted = 3'b001; start = 1'b0;
        #1;
        n_checks++;
        if (dbg !== 3'd0) begin
            n_err++; $display("FAIL abort_dbg got %b exp 000", dbg);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (st !== 3'd0 || dbg !== 3'd0 || act !== 3'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle got st=%0d dbg=%b act=%b busy=%b exp 0 000 000 0",
                     st, dbg, act, busy);
        end
        halted = 3'b111; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        #1;
        n_checks++;
        if (st !== 3'd3 || sync !== 1'b0) begin
            n_err++;
            $display("FAIL abort_resume got st=%0d sync=%b exp st=3 sync=0", st, sync);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (st !== 3'd0) begin
            n_err++; $display("FAIL abort_resume_idle got %0d exp 0", st);
        end
        halted = 3'd0; safe = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; endsw = 1'b1;
        #1;
        n_checks++;
        if (ack !== 1'b0) begin
            n_err++; $display("FAIL abort_run_ack got %b exp 0", ack);
        end
        @(negedge clk);
        endsw = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        safe = 1'b1; cfg = 2'd0; master = 3'b001; halted = 3'd0; start = 1'b1;
        @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({dbg, act, sync, busy, ack, terr, st} !== 15'd0) begin
            n_err++;
            $display("FAIL async_rst_hreq got %b exp 0", {dbg, act, sync, busy, ack, terr, st});
        end
        @(negedge clk);
        start = 1'b0; rst_ni = 1'b1;
        @(negedge clk);
        safe = 1'b0; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({dbg, act, sync, busy, ack, terr, st} !== 15'd0) begin
            n_err++;
            $display("FAIL async_rst_run got %b exp 0", {dbg, act, sync, busy, ack, terr, st});
        end
        @(negedge clk);
        start = 1'b0; rst_ni = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random;
        bit ok;
        for (int i = 0; i < 20; i++) begin
            do_safe_run(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                        int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                        int'($urandom_range(0, 9)), ok);
            if (ok) finish_run(int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset;
        test_tmr;
        test_dmr;
        test_timeout;
        test_critical;
        test_nonsafe;
        test_abort;
        test_async_reset;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
